// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: single-outstanding imem read, held instruction behind
// valid/ready, immediate extraction and branch/jump resolution for the PC block.
module fetch_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        EQ,
    output logic        pc_en,
    output logic        PCsrc,
    output logic [31:0] ImmOp,
    output logic [7:0]  timeout_cnt
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Last wait-count value before a reissue; WAIT lasts TIMEOUT cycles in total.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign imem_req    = (state == S_REQ);
    assign imem_addr   = PC;
    assign instr_valid = (state == S_HOLD);
    assign pc_en       = (state == S_HOLD) && instr_ready;

    // Fetch sequencing, instruction capture and request-timeout bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            wait_cnt    <= 8'd0;
            instr       <= 32'd0;
            timeout_cnt <= 8'd0;
        end else begin
            case (state)
                S_REQ: begin
                    wait_cnt <= 8'd0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr <= imem_rdata;
                        state <= S_HOLD;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= 8'd0;
                        state    <= S_REQ;
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end else begin
                            timeout_cnt <= timeout_cnt;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        state <= S_REQ;
                    end else begin
                        state <= S_HOLD;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    // Immediate decode by instruction format.
    always_comb begin
        ImmOp = 32'd0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR:
                ImmOp = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                ImmOp = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                ImmOp = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                ImmOp = {instr[31:12], 12'd0};
            OP_JAL:
                ImmOp = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                ImmOp = 32'd0;
        endcase
    end

    // Take-target decision; JALR deliberately falls through to PC+4.
    always_comb begin
        PCsrc = 1'b0;
        if (pc_en) begin
            case (opcode)
                OP_JAL: PCsrc = 1'b1;
                OP_BRANCH: begin
                    case (funct3)
                        3'b000:  PCsrc = EQ;
                        3'b001:  PCsrc = ~EQ;
                        default: PCsrc = 1'b0;
                    endcase
                end
                default: PCsrc = 1'b0;
            endcase
        end else begin
            PCsrc = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected decode results are queued when a memory
// response is driven and compared when the consumer handshake takes the instruction.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] PC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        EQ = 1'b0;
    logic        pc_en;
    logic        PCsrc;
    logic [31:0] ImmOp;
    logic [7:0]  timeout_cnt;

    localparam logic [31:0] PC_RESET = 32'h0000_1000;

    typedef struct {
        logic [31:0] w;
        logic [31:0] imm;
        logic        src;
        logic        eq;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_pc = PC_RESET;
    int          checks = 0;
    int          errors = 0;

    fetch_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .PC(PC),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .EQ(EQ), .pc_en(pc_en), .PCsrc(PCsrc), .ImmOp(ImmOp),
        .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    // PC block as integrated: loads only when pc_en is high.
    always @(posedge clk) begin
        if (rst) PC <= PC_RESET;
        else if (pc_en) PC <= PCsrc ? PC + ImmOp : PC + 32'd4;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] imm_ref(input logic [31:0] w);
        logic [12:0] b;
        logic [20:0] j;
        b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        case (w[6:0])
            7'h13, 7'h03, 7'h67: return {{20{w[31]}}, w[31:20]};
            7'h23:               return {{20{w[31]}}, w[31:25], w[11:7]};
            7'h63:               return {{19{b[12]}}, b};
            7'h37, 7'h17:        return {w[31:12], 12'h000};
            7'h6F:               return {{11{j[20]}}, j};
            default:             return 32'd0;
        endcase
    endfunction

    function automatic logic pcsrc_ref(input logic [31:0] w, input logic eq);
        if (w[6:0] == 7'h6F) return 1'b1;
        if (w[6:0] == 7'h63 && w[14:12] == 3'd0) return eq;
        if (w[6:0] == 7'h63 && w[14:12] == 3'd1) return !eq;
        return 1'b0;
    endfunction

    // Starts in a REQ cycle; returns in the first HOLD cycle.
    task automatic fetch_to_hold(input logic [31:0] word, input int lat, input logic eq);
        exp_t e;
        #1;
        check("req", {31'd0, imem_req}, 32'd1);
        check("addr", imem_addr, exp_pc);
        e.w = word; e.imm = imm_ref(word); e.src = pcsrc_ref(word, eq); e.eq = eq;
        sb.push_back(e);
        for (int k = 1; k <= lat; k++) begin
            cyc();
            imem_rvalid = (k == lat);
            imem_rdata  = word;
            #1;
            check("req_wait", {31'd0, imem_req}, 32'd0);
        end
        cyc();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        check("valid_hold", {31'd0, instr_valid}, 32'd1);
    endtask

    // Stalls for 'stall' HOLD cycles, then handshakes; returns in the following REQ cycle.
    task automatic handshake(input int stall);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb[0];
        for (int s = 0; s < stall; s++) begin
            instr_ready = 1'b0;
            EQ = ~e.eq;
            #1;
            check("stall_instr", instr, e.w);
            check("stall_imm", ImmOp, e.imm);
            check("stall_pc_en", {31'd0, pc_en}, 32'd0);
            check("stall_pcsrc", {31'd0, PCsrc}, 32'd0);
            check("stall_req", {31'd0, imem_req}, 32'd0);
            cyc();
        end
        instr_ready = 1'b1;
        EQ = e.eq;
        #1;
        e = sb.pop_front();
        check("hs_instr", instr, e.w);
        check("hs_imm", ImmOp, e.imm);
        check("hs_pc_en", {31'd0, pc_en}, 32'd1);
        check("hs_pcsrc", {31'd0, PCsrc}, {31'd0, e.src});
        exp_pc = e.src ? exp_pc + e.imm : exp_pc + 32'd4;
        cyc();
        instr_ready = 1'b0;
        EQ = 1'b0;
        #1;
        check("next_req", {31'd0, imem_req}, 32'd1);
        check("next_pc_en", {31'd0, pc_en}, 32'd0);
        check("next_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] word, input int lat, input logic eq, input int stall);
        fetch_to_hold(word, lat, eq);
        handshake(stall);
    endtask

    // Single-cycle reset pulse; returns in the first REQ cycle after release.
    task automatic rst_pulse();
        rst = 1'b1;
        sb.delete();
        cyc();
        rst = 1'b0;
        exp_pc = PC_RESET;
    endtask

    initial begin
        rst = 1'b1;
        cyc();
        cyc();
        #1;
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_imm", ImmOp, 32'd0);
        check("rst_pc_en", {31'd0, pc_en}, 32'd0);
        check("rst_pcsrc", {31'd0, PCsrc}, 32'd0);
        check("rst_tocnt", {24'd0, timeout_cnt}, 32'd0);
        rst = 1'b0;

        fetch(32'h0050_0093, 1, 1'b0, 0);   // addi x1,x0,5
        fetch(32'hFE00_9EE3, 1, 1'b0, 0);   // bne taken
        fetch(32'hFE00_9EE3, 2, 1'b1, 0);   // bne not taken
        fetch(32'hFE00_8EE3, 1, 1'b1, 0);   // beq taken
        fetch(32'h0080_00EF, 1, 1'b0, 0);   // jal
        fetch(32'h0080_00EF, 3, 1'b1, 0);
        fetch(32'h0000_C463, 1, 1'b1, 0);   // blt: never taken here
        fetch(32'h0101_00E7, 1, 1'b0, 0);   // jalr: never taken
        fetch(32'h0011_2623, 1, 1'b0, 5);   // sw with 5-cycle stall
        fetch(32'h1234_50B7, 1, 1'b0, 0);   // lui
        fetch(32'hFFF0_0093, 4, 1'b0, 0);   // addi -1
        fetch(32'h0000_0033, 1, 1'b0, 1);   // R-type: no immediate

        // No response: reissue every 16 cycles.
        for (int n = 1; n <= 3; n++) begin
            for (int t = 1; t <= 16; t++) begin
                cyc();
                #1;
                check("to_req", {31'd0, imem_req}, {31'd0, t == 16});
            end
            check("to_cnt", {24'd0, timeout_cnt}, n);
            check("to_addr", imem_addr, exp_pc);
        end
        imem_rvalid = 1'b1;                 // response in the REQ cycle is not sampled
        imem_rdata  = 32'h0050_0093;
        cyc();
        imem_rvalid = 1'b0;
        #1;
        check("late_valid", {31'd0, instr_valid}, 32'd0);
        for (int t = 2; t <= 16; t++) begin
            cyc();
            #1;
            if (t == 2) check("late_valid2", {31'd0, instr_valid}, 32'd0);
            if (t == 16) check("late_req", {31'd0, imem_req}, 32'd1);
        end
        check("late_cnt", {24'd0, timeout_cnt}, 32'd4);
        fetch(32'h0080_00EF, 1, 1'b0, 0);

        // Reset while in WAIT; an rvalid in the following REQ cycle is dropped.
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_pc = PC_RESET;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        instr_ready = 1'b1;
        #1;
        check("rw_req", {31'd0, imem_req}, 32'd1);
        check("rw_valid", {31'd0, instr_valid}, 32'd0);
        check("rw_instr", instr, 32'd0);
        check("rw_pc_en", {31'd0, pc_en}, 32'd0);
        check("rw_tocnt", {24'd0, timeout_cnt}, 32'd0);
        cyc();
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        #1;
        check("rw_after", {31'd0, instr_valid}, 32'd0);
        check("rw_instr2", instr, 32'd0);
        rst_pulse();
        fetch(32'hFE00_9EE3, 1, 1'b0, 0);

        // Reset while in HOLD.
        fetch_to_hold(32'h1234_50B7, 1, 1'b0);
        rst_pulse();
        instr_ready = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0080_00EF;
        #1;
        check("rh_valid", {31'd0, instr_valid}, 32'd0);
        check("rh_instr", instr, 32'd0);
        check("rh_pc_en", {31'd0, pc_en}, 32'd0);
        check("rh_pcsrc", {31'd0, PCsrc}, 32'd0);
        check("rh_req", {31'd0, imem_req}, 32'd1);
        cyc();
        instr_ready = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        check("rh_after", {31'd0, instr_valid}, 32'd0);
        check("rh_imm", ImmOp, 32'd0);
        rst_pulse();
        fetch(32'h0050_0093, 1, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that consumes the current `PC` from the program-counter block and drives its branch controls (`ImmOp`, `PCsrc`) plus a new advance strobe `pc_en`. It issues a single-outstanding read to instruction memory, holds the returned word for decode/execute behind a valid/ready handshake, and extracts the immediate. On handshake it resolves jumps and conditional branches (BEQ/BNE, using the ALU `EQ` flag) and tells the PC block whether to take `PC + ImmOp`.

## Interface
- `TIMEOUT`, 15: max cycles spent in WAIT before the request is reissued (1..255).
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `PC` in 32: current fetch address from the PC block.
- `imem_req` out 1: one-cycle read strobe to instruction memory.
- `imem_addr` out 32: read address, equal to `PC` when `imem_req`=1.
- `imem_rdata` in 32: returned instruction word.
- `imem_rvalid` in 1: `imem_rdata` valid this cycle.
- `instr` out 32: held instruction to decode.
- `instr_valid` out 1: `instr` valid.
- `instr_ready` in 1: consumer accepts `instr` this cycle.
- `EQ` in 1: ALU equality flag for the held instruction, sampled on handshake.
- `pc_en` out 1: PC register loads next value at this edge.
- `PCsrc` out 1: next PC = `PC + ImmOp` (1) or `PC + 4` (0).
- `ImmOp` out 32: sign-extended immediate of `instr`.
- `timeout_cnt` out 8: saturating count of reissued requests.

## Operation
- FSM states REQ, WAIT, HOLD. Reset enters REQ.
- REQ: `imem_req`=1, `imem_addr`=`PC`, clear wait counter, go WAIT unconditionally.
- WAIT: if `imem_rvalid`, capture `imem_rdata` into `instr`, go HOLD. Otherwise increment the wait counter; when it reaches `TIMEOUT`, go REQ and increment `timeout_cnt` (saturates at 255).
- HOLD: `instr_valid`=1. On `instr_ready`: `pc_en`=1 for that cycle, go REQ. Otherwise stay and hold `instr` stable.
- `imem_rvalid` outside WAIT is ignored; the stale response is dropped.
- `ImmOp` is combinational from `instr`, selected on opcode `instr[6:0]`:
  - I (0010011, 0000011, 1100111): sext `instr[31:20]`.
  - S (0100011): sext {`[31:25]`, `[11:7]`}.
  - B (1100011): sext {`[31]`, `[7]`, `[30:25]`, `[11:8]`, 0}.
  - U (0110111, 0010111): {`[31:12]`, 12'b0}.
  - J (1101111): sext {`[31]`, `[19:12]`, `[20]`, `[30:21]`, 0}.
  - Otherwise 0.
- `PCsrc` = `pc_en` AND (JAL, OR B-type funct3=000 with `EQ`=1, OR B-type funct3=001 with `EQ`=0). Other funct3 values give `PCsrc`=0. JALR gives 0; register-indirect targets are out of scope.
- `PCsrc` is 0 whenever `pc_en`=0.
- The PC register updates only on edges where `pc_en`=1. This is an integration requirement on the PC block.

## Timing
- Reset values: state REQ, `instr`=0, `instr_valid`=0, `pc_en`=0, `PCsrc`=0, `ImmOp`=0, `timeout_cnt`=0, wait counter 0.
- `imem_req` is combinational from state, so it is 1 in the first cycle after reset release.
- Minimum 3 cycles per instruction: REQ, WAIT with `rvalid` in the first WAIT cycle, HOLD with `ready` in the first HOLD cycle.
- Memory latency is 1 cycle minimum: `rvalid` in the same cycle as `imem_req` is not sampled.
- `pc_en`/`PCsrc` are combinational in the handshake cycle. `PC` changes at the following edge and is stable in the next REQ.
- `rst` in any state overrides everything: it aborts the outstanding request, drops the held instruction and outputs reset values next cycle. Any late `rvalid` after reset lands in REQ and is ignored.
- Timeout: with no `rvalid`, REQ reissues exactly `TIMEOUT`+1 cycles after the previous REQ.

## Test plan
- Reset then `imem_rdata`=0x00500093 (addi x1,x0,5) with 1-cycle latency, `ready`=1 -> `imem_req` in cycles 0 and 3; `ImmOp`=5; `pc_en`=1 with `PCsrc`=0 in cycle 2.
- BNE 0xFE009EE3 in HOLD with `EQ`=0, `ready`=1 -> `ImmOp`=0xFFFFFFFC, `PCsrc`=1. Same word with `EQ`=1 -> `PCsrc`=0.
- JAL 0x008000EF -> `ImmOp`=8, `PCsrc`=1 on handshake regardless of `EQ`.
- `instr_ready` held 0 for 5 cycles in HOLD -> `instr` and `ImmOp` stable, `pc_en`=0, no `imem_req`. `ready`=1 in cycle 6 -> single `pc_en` pulse.
- `imem_rvalid` never asserted, `TIMEOUT`=15 -> `imem_req` every 16 cycles, `timeout_cnt` increments 1,2,3. Late `rvalid` arriving in REQ is ignored.
- `rst` asserted in WAIT and in HOLD -> next cycle `instr_valid`=0, `pc_en`=0, `instr`=0, state REQ. An `rvalid` in that cycle is not captured.
